// File: rtl/inst_uart_loader.sv
// ============================================================================
// Module   : inst_uart_loader
// Purpose  : 8N1 UART program loader feeding the instruction-memory write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_uart_loader #(
    parameter int CLK_PER_BIT = 868,
    parameter int ADDR_W      = 14,
    parameter int MAX_WORDS   = 9400
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RXD,
    output logic              INST_WE,
    output logic [ADDR_W-1:0] INST_ADDR,
    output logic [31:0]       INST_WDATA,
    output logic              LOAD_DONE,
    output logic              LOAD_ERR
);

    localparam int c_bit_cnt_w  = $clog2(CLK_PER_BIT);
    localparam int c_word_cnt_w = $clog2(MAX_WORDS + 1);

    localparam logic [c_bit_cnt_w-1:0]  c_half      = c_bit_cnt_w'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_full      = c_bit_cnt_w'(CLK_PER_BIT - 1);
    localparam logic [c_bit_cnt_w-1:0]  c_bit_one   = c_bit_cnt_w'(1);
    localparam logic [c_word_cnt_w-1:0] c_word_one  = c_word_cnt_w'(1);
    localparam logic [31:0]             c_max_words = 32'(MAX_WORDS);
    localparam logic [3:0]              c_stop_idx  = 4'd9;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // ---------------- RX bit engine ----------------
    logic                   r_rxd_meta;
    logic                   r_rxd_sync;
    logic                   r_rxd_prev;
    logic                   r_rx_busy;
    logic [c_bit_cnt_w-1:0] r_bit_cnt;
    logic [3:0]             r_bit_idx;
    logic [7:0]             r_shift;

    logic w_start;
    logic w_sample;
    logic w_byte_valid;
    logic w_frame_err;

    always_comb begin
        w_start      = !r_rx_busy && r_rxd_prev && !r_rxd_sync;
        w_sample     = r_rx_busy && (r_bit_cnt == '0);
        w_byte_valid = w_sample && (r_bit_idx == c_stop_idx) && r_rxd_sync;
        w_frame_err  = w_sample && (r_bit_idx == c_stop_idx) && !r_rxd_sync;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_rxd_meta <= RXD;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
            if (w_start) begin
                r_rx_busy <= 1'b1;
                r_bit_cnt <= c_half;
                r_bit_idx <= '0;
            end else if (r_rx_busy) begin
                if (r_bit_cnt != '0) begin
                    r_bit_cnt <= r_bit_cnt - c_bit_one;
                end else begin
                    r_bit_cnt <= c_full;
                    r_bit_idx <= r_bit_idx + 4'd1;
                    // A start bit that reads high was a glitch: drop it.
                    if (r_bit_idx == 4'd0 && r_rxd_sync)
                        r_rx_busy <= 1'b0;
                    if (r_bit_idx >= 4'd1 && r_bit_idx <= 4'd8)
                        r_shift <= {r_rxd_sync, r_shift[7:1]};
                    if (r_bit_idx == c_stop_idx)
                        r_rx_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- Framing FSM ----------------
    state_t                  r_state;
    logic [1:0]              r_byte_cnt;
    logic [23:0]             r_asm;
    logic [c_word_cnt_w-1:0] r_n;
    logic [c_word_cnt_w-1:0] r_word_cnt;

    logic [31:0]             w_asm_next;
    logic [c_word_cnt_w-1:0] w_word_next;

    always_comb begin
        w_asm_next  = {r_asm, r_shift};
        w_word_next = r_word_cnt + c_word_one;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= S_HDR;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_n        <= '0;
            r_word_cnt <= '0;
            INST_WE    <= 1'b0;
            INST_ADDR  <= '0;
            INST_WDATA <= '0;
            LOAD_DONE  <= 1'b0;
            LOAD_ERR   <= 1'b0;
        end else begin
            INST_WE <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_frame_err) begin
                        r_state  <= S_ERR;
                        LOAD_ERR <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_asm      <= w_asm_next[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_byte_cnt <= '0;
                            if (w_asm_next == '0) begin
                                r_state   <= S_DONE;
                                LOAD_DONE <= 1'b1;
                            end else if (w_asm_next > c_max_words) begin
                                r_state  <= S_ERR;
                                LOAD_ERR <= 1'b1;
                            end else begin
                                r_state    <= S_LOAD;
                                r_n        <= w_asm_next[c_word_cnt_w-1:0];
                                r_word_cnt <= '0;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (w_frame_err) begin
                        r_state  <= S_ERR;
                        LOAD_ERR <= 1'b1;
                    end else if (w_byte_valid) begin
                        r_asm      <= w_asm_next[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            INST_WE    <= 1'b1;
                            INST_ADDR  <= ADDR_W'(r_word_cnt);
                            INST_WDATA <= w_asm_next;
                            r_word_cnt <= w_word_next;
                            // Done flag rises with the final strobe.
                            if (w_word_next == r_n) begin
                                r_state    <= S_DONE;
                                r_byte_cnt <= '0;
                                LOAD_DONE  <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    LOAD_DONE <= 1'b1;
                end
                default: begin
                    LOAD_ERR  <= 1'b1;
                    LOAD_DONE <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_uart_loader.sv
// ============================================================================
// Module   : tb_inst_uart_loader
// Purpose  : Directed vector bench for the UART program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inst_uart_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 14;
    localparam int MAXW   = 16;

    logic              CLK   = 1'b0;
    logic              RST_N = 1'b0;
    logic              RXD   = 1'b1;
    logic              INST_WE;
    logic [ADDR_W-1:0] INST_ADDR;
    logic [31:0]       INST_WDATA;
    logic              LOAD_DONE;
    logic              LOAD_ERR;

    inst_uart_loader #(
        .CLK_PER_BIT(CPB),
        .ADDR_W     (ADDR_W),
        .MAX_WORDS  (MAXW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .RXD       (RXD),
        .INST_WE   (INST_WE),
        .INST_ADDR (INST_ADDR),
        .INST_WDATA(INST_WDATA),
        .LOAD_DONE (LOAD_DONE),
        .LOAD_ERR  (LOAD_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [ADDR_W-1:0] wr_addr_q[$];
    logic [31:0]       wr_data_q[$];
    logic              wr_done_q[$];
    int                wr_cyc_q[$];
    int                done_cyc = -1000;
    int                err_cyc  = -1000;
    bit                done_seen = 1'b0;
    bit                err_seen  = 1'b0;
    int                last_start_cyc = 0;

    always @(negedge CLK) begin
        if (INST_WE === 1'b1) begin
            wr_addr_q.push_back(INST_ADDR);
            wr_data_q.push_back(INST_WDATA);
            wr_done_q.push_back(LOAD_DONE);
            wr_cyc_q.push_back(cyc);
        end
        if (LOAD_DONE === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (LOAD_ERR === 1'b1 && !err_seen) begin
            err_seen = 1'b1;
            err_cyc  = cyc;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        RXD   = 1'b1;
        @(posedge CLK);
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_done_q.delete();
        wr_cyc_q.delete();
        done_seen = 1'b0;
        err_seen  = 1'b0;
        done_cyc  = -1000;
        err_cyc   = -1000;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("rst_we",    32'(INST_WE),    32'd0);
        chk("rst_addr",  32'(INST_ADDR),  32'd0);
        chk("rst_wdata", INST_WDATA,      32'd0);
        chk("rst_done",  32'(LOAD_DONE),  32'd0);
        chk("rst_err",   32'(LOAD_ERR),   32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge that ends the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
        last_start_cyc = cyc;
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = stop_lvl;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b1);
    endtask

    typedef struct {
        logic [31:0] hdr;
        int          nw;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_writes;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hdr_c;
        int fe_c;
        logic [31:0] exp_d;

        vecs[0] = '{32'd2,  2, 32'h20010005, 32'hAC010000, 2, 1'b1, 1'b0};
        vecs[1] = '{32'd0,  1, 32'h55AA55AA, 32'h0,        0, 1'b1, 1'b0};
        vecs[2] = '{32'h11, 2, 32'h01020304, 32'h05060708, 0, 1'b0, 1'b1};
        vecs[3] = '{32'd1,  1, 32'h0000000C, 32'h0,        1, 1'b1, 1'b0};
        vecs[4] = '{32'd1,  2, 32'hCAFEF00D, 32'h12345678, 1, 1'b1, 1'b0};
        vecs[5] = '{32'd16, 2, 32'h89ABCDEF, 32'h76543210, 2, 1'b0, 1'b0};

        for (int r = 0; r < 6; r++) begin
            do_reset();
            send_word(vecs[r].hdr);
            hdr_c = last_start_cyc;
            for (int j = 0; j < vecs[r].nw; j++)
                send_word(j == 0 ? vecs[r].w0 : vecs[r].w1);
            repeat (10) @(negedge CLK);

            chk($sformatf("v%0d_nwrites", r), 32'(wr_data_q.size()), 32'(vecs[r].exp_writes));
            for (int i = 0; i < vecs[r].exp_writes; i++) begin
                exp_d = (i == 0) ? vecs[r].w0 : vecs[r].w1;
                chk($sformatf("v%0d_addr%0d", r, i),
                    (i < wr_addr_q.size()) ? 32'(wr_addr_q[i]) : 32'hFFFFFFFF, 32'(i));
                chk($sformatf("v%0d_data%0d", r, i),
                    (i < wr_data_q.size()) ? wr_data_q[i] : ~exp_d, exp_d);
            end
            chk($sformatf("v%0d_done", r), 32'(LOAD_DONE), 32'(vecs[r].exp_done));
            chk($sformatf("v%0d_err", r),  32'(LOAD_ERR),  32'(vecs[r].exp_err));
            if (vecs[r].exp_done && vecs[r].exp_writes > 0) begin
                chk($sformatf("v%0d_done_at_last_we", r), 32'(done_cyc),
                    (wr_cyc_q.size() > 0) ? 32'(wr_cyc_q[wr_cyc_q.size()-1]) : 32'hFFFFFFFF);
                if (vecs[r].exp_writes > 1)
                    chk($sformatf("v%0d_done_low_first_we", r),
                        (wr_done_q.size() > 0) ? 32'(wr_done_q[0]) : 32'd1, 32'd0);
            end
            if (vecs[r].exp_done && vecs[r].exp_writes == 0)
                chk_rng($sformatf("v%0d_done_lat", r), done_cyc - hdr_c, 78, 80);
            if (vecs[r].exp_err)
                chk_rng($sformatf("v%0d_err_lat", r), err_cyc - hdr_c, 78, 80);
        end

        // Framing error on the third data byte of an N=1 load.
        do_reset();
        send_word(32'd1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b0);
        fe_c = last_start_cyc;
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        chk_rng("fe_err_lat", err_cyc - fe_c, 78, 80);
        chk("fe_err",  32'(LOAD_ERR),  32'd1);
        chk("fe_done", 32'(LOAD_DONE), 32'd0);
        send_byte(8'h78, 1'b1);
        send_word(32'h9ABCDEF0);
        repeat (10) @(negedge CLK);
        chk("fe_nwrites", 32'(wr_data_q.size()), 32'd0);
        chk("fe_err_held", 32'(LOAD_ERR), 32'd1);

        // Short low glitch while idle, then a one-word load.
        do_reset();
        RXD = 1'b0;
        repeat (3) @(negedge CLK);
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        send_word(32'd1);
        send_word(32'h0000000C);
        repeat (10) @(negedge CLK);
        chk("gl_nwrites", 32'(wr_data_q.size()), 32'd1);
        chk("gl_addr", (wr_addr_q.size() > 0) ? 32'(wr_addr_q[0]) : 32'hFFFFFFFF, 32'd0);
        chk("gl_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hFFFFFFFF, 32'h0000000C);
        chk("gl_done", 32'(LOAD_DONE), 32'd1);
        chk("gl_err",  32'(LOAD_ERR),  32'd0);

        // Reset in the middle of an N=3 load, then a fresh one-word load.
        do_reset();
        send_word(32'd3);
        send_word(32'h11111111);
        for (int k = 0; k < 200 && wr_data_q.size() == 0; k++) @(negedge CLK);
        chk("rs_first_write", 32'(wr_data_q.size()), 32'd1);
        do_reset();
        send_word(32'd1);
        send_word(32'hDEADBEEF);
        repeat (10) @(negedge CLK);
        chk("rs_nwrites", 32'(wr_data_q.size()), 32'd1);
        chk("rs_addr", (wr_addr_q.size() > 0) ? 32'(wr_addr_q[0]) : 32'hFFFFFFFF, 32'd0);
        chk("rs_data", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, 32'hDEADBEEF);
        chk("rs_done", 32'(LOAD_DONE), 32'd1);
        chk("rs_err",  32'(LOAD_ERR),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
